param_updown_counter: RTL
=========================

Name: param_updown_counter

Overview:
- Parametrised successor to the 4-bit ripple down counter; fully synchronous design with an asynchronous reset.
- Provides:
  - runtime-selectable up/down counting over a modulus range 0..MODULO-1;
  - enable, synchronous clear and parallel load;
  - a free-running or one-shot mode;
  - terminal-count, wrap and done status outputs.
- Used as the common timer/divider primitive in place of fixed-width ripple counters.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.
- MODULO, 16, count range size; q stays within 0..MODULO-1; legal range 2..2**WIDTH.
- ONESHOT, 0, 0 = free-running (wraps at terminal), 1 = stop at terminal and assert done.
- RESET_VAL, 0, value loaded into q on reset; must be < MODULO.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable; one step per clk while high.
- up_dn  input  1  direction: 1 = up, 0 = down; sampled every cycle.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  current count, registered.
- tc  output  1  combinational terminal count: high when the next enabled step would cross the boundary.
- wrap  output  1  registered one-cycle pulse, high in the cycle after q wraps.
- done  output  1  one-shot mode only: sticky flag indicating the terminal value was reached.
- load_err  output  1  registered one-cycle pulse indicating a load_val >= MODULO was clamped.

Behaviour:
- Reset (rst = 0, asynchronous, takes effect immediately):
  - q = RESET_VAL;
  - wrap = 0, done = 0, load_err = 0.
- Release of rst is synchronous to clk; the first update occurs on the first rising edge with rst = 1.
- Priority per rising edge: clr > load > en. Lower-priority actions are ignored in that cycle.
- clr: q <= 0; done <= 0. No wrap pulse.
- load:
  - if load_val < MODULO, then q <= load_val;
  - otherwise q <= MODULO-1 and load_err pulses for 1 cycle;
  - done <= 0. No wrap pulse.
- en with up_dn = 1:
  - if q < MODULO-1, then q <= q+1;
  - if q == MODULO-1 and ONESHOT = 0, then q <= 0 and wrap pulses;
  - if q == MODULO-1 and ONESHOT = 1, then q holds and done <= 1.
- en with up_dn = 0:
  - if q > 0, then q <= q-1;
  - if q == 0 and ONESHOT = 0, then q <= MODULO-1 and wrap pulses;
  - if q == 0 and ONESHOT = 1, then q holds and done <= 1.
- done in one-shot mode:
  - also sets on the step that lands q on the terminal value, i.e. done is high from the cycle in which q first equals the terminal value;
  - once done is set, en has no effect until clr or load.
- en = 0: q holds; wrap stays 0.
- tc = en & (up_dn ? q == MODULO-1 : q == 0). tc is purely combinational from the current inputs and q.
- Direction change: takes effect on the edge where the new up_dn is sampled. No extra latency.
- Arithmetic:
  - all compares are unsigned at WIDTH bits;
  - MODULO-1 is computed at WIDTH+1 bits so that MODULO = 2**WIDTH is legal;
  - q never leaves 0..MODULO-1 under any input sequence.
- Latency: q reflects clr, load or a count step one clk edge after the input is sampled.
- Reset mid-operation: all state returns to reset values immediately, regardless of clk.
- Elaboration guard: simulation $error if MODULO < 2, MODULO > 2**WIDTH, or RESET_VAL >= MODULO.

Test Plan:
- Default parameters, rst low for 2 cycles, then en = 1, up_dn = 0, for 20 cycles:
  - q = 0, 15, 14, …, 0, 15, 14, 13, 12, …;
  - wrap pulses once, the cycle after each 0→15 transition;
  - tc is high while q = 0.
- WIDTH = 4, MODULO = 10, up_dn = 1, en = 1 for 12 cycles:
  - q = 0..9, 0, 1;
  - wrap is high for exactly 1 cycle after 9→0;
  - q never shows 10–15.
- ONESHOT = 1, MODULO = 10, load_val = 3 with load, then down-count:
  - q = 3, 2, 1, 0, 0, 0;
  - done rises in the cycle q becomes 0 and stays high;
  - a subsequent load of 5 clears done and gives q = 5.
- Priority: with q = 7, assert clr = 1, load = 1 (load_val = 2) and en = 1 in the same cycle:
  - q = 0 next;
  - then assert load = 1 and en = 1 together: q = 2, with no count step.
- MODULO = 10, load_val = 12: q = 9 and load_err pulses for 1 cycle.
- Async reset mid-count: with q = 6, assert rst low between clk edges:
  - q = RESET_VAL immediately, without waiting for a clk edge;
  - done, wrap and load_err = 0;
  - counting resumes from RESET_VAL on the first edge after release.

Source files
------------

// File: rtl/param_updown_counter_if.sv
// Counter control/status bundle: control inputs driven by the user (master),
// count and status returned by the counter (slave).
// clk and rst are deliberately kept outside the bundle as plain ports.
interface param_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             done;
  logic             load_err;

  modport master (
    output en, up_dn, clr, load, load_val,
    input  q, tc, wrap, done, load_err
  );

  modport slave (
    input  en, up_dn, clr, load, load_val,
    output q, tc, wrap, done, load_err
  );
endinterface

// File: rtl/param_updown_counter.sv
// Modulo-MODULO up/down counter with clear, load, enable and optional one-shot stop.
// Latency: q/wrap/done/load_err update one clk edge after inputs are sampled; tc is combinational.
// No backpressure: every enabled edge steps, priority clr > load > en.
module param_updown_counter #(
  parameter int              WIDTH     = 4,
  parameter longint unsigned MODULO    = 16,
  parameter int              ONESHOT   = 0,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  param_updown_counter_if.slave bus
);

  // MODULO and MODULO-1 are held at WIDTH+1 bits so MODULO = 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT = MODULO[WIDTH:0];
  localparam logic [WIDTH:0]   MAX_EXT = MOD_EXT - 1'b1;
  localparam logic [WIDTH-1:0] MAX_Q   = MAX_EXT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_Q   = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(1);
  localparam bit               OS      = (ONESHOT != 0);
  localparam longint unsigned  MOD_LIMIT = 64'd1 << WIDTH;

  // Reject parameter sets that would let q escape its legal range.
  if (MODULO < 2 || MODULO > MOD_LIMIT || RESET_VAL >= MODULO) begin : g_param_check
    $error("param_updown_counter: illegal MODULO/RESET_VAL for WIDTH");
  end

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic             done_r;
  logic             err_r;

  logic             at_max;
  logic             at_zero;
  logic             load_ok;
  logic [WIDTH-1:0] q_inc;
  logic [WIDTH-1:0] q_dec;

  assign at_max  = (q_r == MAX_Q);
  assign at_zero = (q_r == '0);
  assign load_ok = ({1'b0, bus.load_val} < MOD_EXT);
  assign q_inc   = q_r + ONE_Q;
  assign q_dec   = q_r - ONE_Q;

  // Terminal count looks only at current inputs and q; it ignores done on purpose.
  assign bus.tc       = bus.en & (bus.up_dn ? at_max : at_zero);
  assign bus.q        = q_r;
  assign bus.wrap     = wrap_r;
  assign bus.done     = done_r;
  assign bus.load_err = err_r;

  // Count state: clear beats load beats count; wrap/load_err are single-cycle pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r    <= RST_Q;
      wrap_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      wrap_r <= 1'b0;
      err_r  <= 1'b0;
      if (bus.clr) begin
        q_r    <= '0;
        done_r <= 1'b0;
      end else if (bus.load) begin
        // Out-of-range loads saturate to the top of the range and flag it.
        q_r    <= load_ok ? bus.load_val : MAX_Q;
        err_r  <= ~load_ok;
        done_r <= 1'b0;
      end else if (bus.en && !done_r) begin
        if (bus.up_dn) begin
          if (!at_max) begin
            q_r <= q_inc;
            // One-shot: done rises together with q landing on the terminal value.
            if (OS && (q_inc == MAX_Q)) begin
              done_r <= 1'b1;
            end
          end else if (OS) begin
            done_r <= 1'b1;
          end else begin
            q_r    <= '0;
            wrap_r <= 1'b1;
          end
        end else begin
          if (!at_zero) begin
            q_r <= q_dec;
            if (OS && (q_r == ONE_Q)) begin
              done_r <= 1'b1;
            end
          end else if (OS) begin
            done_r <= 1'b1;
          end else begin
            q_r    <= MAX_Q;
            wrap_r <= 1'b1;
          end
        end
      end
    end
  end

endmodule
